// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA raster timing generator. It produces the horizontal and
// vertical counters, the sync pulses (with configurable polarity), the
// blanking flags and the visible-area flag. It also produces a "fetch" window
// that runs PRE clocks ahead of the visible area, so that pipelined pixel
// sources can prefetch.
//
// Ports:
//   clk        pixel-domain clock
//   rst        synchronous reset, active high (dominates ce)
//   ce         pixel enable; counters advance only when high
//   hcount     horizontal position, 0..H_TOTAL-1
//   vcount     line number, 0..V_TOTAL-1
//   hsync      horizontal sync, asserted level H_SYNC_POL
//   vsync      vertical sync, asserted level V_SYNC_POL
//   hblank     hcount >= H_VIS
//   vblank     vcount >= V_VIS
//   vis        visible area (~hblank & ~vblank)
//   fetch      visible window advanced by PRE clocks
//   line_end   ce & last pixel of a line (combinational)
//   frame_end  line_end & last line of a frame (combinational)
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int CNT_W      = 12,
    parameter int H_VIS      = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VIS      = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int PRE        = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             hblank,
    output logic             vblank,
    output logic             vis,
    output logic             fetch,
    output logic             line_end,
    output logic             frame_end
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    // Reject configurations whose counters would not fit or whose fetch
    // lead reaches back past the start of the horizontal blanking.
    if (longint'(H_TOTAL - 1) >= (longint'(1) << CNT_W) ||
        longint'(V_TOTAL - 1) >= (longint'(1) << CNT_W)) begin : g_cnt_w_check
        $error("vga_timing_gen: CNT_W too small for H_TOTAL-1 / V_TOTAL-1");
    end
    if (PRE < 0 || PRE > H_FP + H_SYNC + H_BP) begin : g_pre_check
        $error("vga_timing_gen: PRE out of range 0..H_FP+H_SYNC+H_BP");
    end

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VIS);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_VIS + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_VIS + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_VIS + V_FP + V_SYNC - 1);

    // Early part of the fetch window: same line, ending PRE clocks before the
    // visible pixels end. It is empty when PRE swallows the whole visible line.
    localparam bit               HAS_EARLY = (PRE < H_VIS);
    localparam logic [CNT_W-1:0] EARLY_END = HAS_EARLY ? CNT_W'(H_VIS - PRE) : '0;
    // Lead part: the last PRE clocks of the previous line. With PRE=0 this
    // part is empty, so fetch collapses onto vis.
    localparam bit               HAS_LEAD   = (PRE > 0);
    localparam logic [CNT_W-1:0] LEAD_START = HAS_LEAD ? CNT_W'(H_TOTAL - PRE) : '0;

    logic [CNT_W-1:0] h_nxt;
    logic [CNT_W-1:0] v_nxt;
    logic [CNT_W-1:0] v_after;   // line following v_nxt, modulo V_TOTAL
    logic             fetch_nxt;

    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        h_nxt = hcount;
        v_nxt = vcount;
        if (ce) begin
            if (hcount == H_LAST) begin
                h_nxt = '0;
                v_nxt = (vcount == V_LAST) ? '0 : vcount + 1'b1;
            end else begin
                h_nxt = hcount + 1'b1;
            end
        end
    end

    always_comb begin
        v_after   = (v_nxt == V_LAST) ? '0 : v_nxt + 1'b1;
        fetch_nxt = (HAS_EARLY && (v_nxt < V_VIS_C) && (h_nxt < EARLY_END)) ||
                    (HAS_LEAD  && (h_nxt >= LEAD_START) && (v_after < V_VIS_C));
    end

    // The flags are registered from the next-state counters. That keeps them
    // aligned with the hcount/vcount shown in the same cycle and glitch-free.
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount <= '0;
            vcount <= '0;
            hsync  <= ~H_SYNC_POL;
            vsync  <= ~V_SYNC_POL;
            hblank <= 1'b0;
            vblank <= 1'b0;
            fetch  <= HAS_EARLY;
        end else begin
            hcount <= h_nxt;
            vcount <= v_nxt;
            hsync  <= ((h_nxt >= HS_FIRST) && (h_nxt <= HS_LAST)) ? H_SYNC_POL : ~H_SYNC_POL;
            vsync  <= ((v_nxt >= VS_FIRST) && (v_nxt <= VS_LAST)) ? V_SYNC_POL : ~V_SYNC_POL;
            hblank <= (h_nxt >= H_VIS_C);
            vblank <= (v_nxt >= V_VIS_C);
            fetch  <= fetch_nxt;
        end
    end

    assign vis       = ~hblank & ~vblank;
    assign line_end  = ce & (hcount == H_LAST);
    assign frame_end = line_end & (vcount == V_LAST);

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Self-checking bench for vga_timing_gen. Two instances share clk/rst/ce:
//   u_med : reduced raster 80x55 (64 visible x 48 lines), PRE=6, active-low syncs
//   u_sml : 16x8 raster, active-high syncs, PRE=0
// A raster model tracks the linear pixel position of each instance and
// derives every output from the timing rules; it is compared on every
// falling edge. Directed literal checks pin the model at the boundaries.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int M_HV = 64, M_HFP = 4, M_HS = 8, M_HBP = 4;
    localparam int M_VV = 48, M_VFP = 2, M_VS = 2, M_VBP = 3;
    localparam int M_PRE = 6;
    localparam int M_TOT = (M_HV + M_HFP + M_HS + M_HBP) * (M_VV + M_VFP + M_VS + M_VBP);

    localparam int S_HV = 8, S_HFP = 2, S_HS = 3, S_HBP = 3;
    localparam int S_VV = 4, S_VFP = 1, S_VS = 1, S_VBP = 2;
    localparam int S_TOT = (S_HV + S_HFP + S_HS + S_HBP) * (S_VV + S_VFP + S_VS + S_VBP);

    typedef struct {
        logic [11:0] h;
        logic [11:0] v;
        logic        hs, vs, hb, vb, vi, fe, le, fr;
    } exp_t;

    logic clk = 1'b0;
    logic rst, ce;

    logic [11:0] m_h, m_v, s_h, s_v;
    logic m_hs, m_vs, m_hb, m_vb, m_vi, m_fe, m_le, m_fr;
    logic s_hs, s_vs, s_hb, s_vb, s_vi, s_fe, s_le, s_fr;

    int n_checks = 0;
    int n_errors = 0;
    int p_m = 0;
    int p_s = 0;
    bit valid = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CNT_W(12), .H_VIS(M_HV), .H_FP(M_HFP), .H_SYNC(M_HS), .H_BP(M_HBP),
        .V_VIS(M_VV), .V_FP(M_VFP), .V_SYNC(M_VS), .V_BP(M_VBP),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .PRE(M_PRE)
    ) u_med (
        .clk(clk), .rst(rst), .ce(ce), .hcount(m_h), .vcount(m_v),
        .hsync(m_hs), .vsync(m_vs), .hblank(m_hb), .vblank(m_vb), .vis(m_vi),
        .fetch(m_fe), .line_end(m_le), .frame_end(m_fr)
    );

    vga_timing_gen #(
        .CNT_W(12), .H_VIS(S_HV), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_VIS(S_VV), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .PRE(0)
    ) u_sml (
        .clk(clk), .rst(rst), .ce(ce), .hcount(s_h), .vcount(s_v),
        .hsync(s_hs), .vsync(s_vs), .hblank(s_hb), .vblank(s_vb), .vis(s_vi),
        .fetch(s_fe), .line_end(s_le), .frame_end(s_fr)
    );

    // Raster model: outputs as a function of the linear pixel position.
    function automatic exp_t model(input int p, input bit ce_now,
                                   input int hv, hfp, hs, hbp, vv, vfp, vs, vbp,
                                   input bit hpol, vpol, input int pre);
        exp_t e;
        int ht, vt, h, v;
        ht = hv + hfp + hs + hbp;
        vt = vv + vfp + vs + vbp;
        h  = p % ht;
        v  = p / ht;
        e.h  = 12'(h);
        e.v  = 12'(v);
        e.hs = (h >= hv + hfp && h < hv + hfp + hs) ? hpol : ~hpol;
        e.vs = (v >= vv + vfp && v < vv + vfp + vs) ? vpol : ~vpol;
        e.hb = (h >= hv);
        e.vb = (v >= vv);
        e.vi = (h < hv) && (v < vv);
        e.fe = ((v < vv) && (h + pre < hv)) ||
               ((h >= ht - pre) && (((v + 1) % vt) < vv));
        e.le = ce_now && (h == ht - 1);
        e.fr = e.le && (v == vt - 1);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_all(input string tag, input exp_t e,
                           input logic [11:0] h, v,
                           input logic hs, vs, hb, vb, vi, fe, le, fr);
        check({tag, "hcount"},    32'(h),  32'(e.h));
        check({tag, "vcount"},    32'(v),  32'(e.v));
        check({tag, "hsync"},     32'(hs), 32'(e.hs));
        check({tag, "vsync"},     32'(vs), 32'(e.vs));
        check({tag, "hblank"},    32'(hb), 32'(e.hb));
        check({tag, "vblank"},    32'(vb), 32'(e.vb));
        check({tag, "vis"},       32'(vi), 32'(e.vi));
        check({tag, "fetch"},     32'(fe), 32'(e.fe));
        check({tag, "line_end"},  32'(le), 32'(e.le));
        check({tag, "frame_end"}, 32'(fr), 32'(e.fr));
    endtask

    // Model position tracking.
    always @(posedge clk) begin
        if (rst) begin
            p_m   <= 0;
            p_s   <= 0;
            valid <= 1'b1;
        end else if (ce) begin
            p_m <= (p_m + 1) % M_TOT;
            p_s <= (p_s + 1) % S_TOT;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (valid) begin
            cmp_all("med.", model(p_m, ce, M_HV, M_HFP, M_HS, M_HBP, M_VV, M_VFP, M_VS, M_VBP,
                                  1'b0, 1'b0, M_PRE),
                    m_h, m_v, m_hs, m_vs, m_hb, m_vb, m_vi, m_fe, m_le, m_fr);
            cmp_all("sml.", model(p_s, ce, S_HV, S_HFP, S_HS, S_HBP, S_VV, S_VFP, S_VS, S_VBP,
                                  1'b1, 1'b1, 0),
                    s_h, s_v, s_hs, s_vs, s_hb, s_vb, s_vi, s_fe, s_le, s_fr);
            check("sml.fetch_eq_vis", 32'(s_fe), 32'(s_vi));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance with the current ce until the medium model reaches a position,
    // then settle to the falling edge for literal checks.
    task automatic goto(input int target);
        int n = 0;
        while (p_m != target && n < 2 * M_TOT) begin
            tick();
            n++;
        end
        check("goto_reached", 32'(p_m), 32'(target));
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        ce  = 1'b0;
        tick();
        tick();
        @(negedge clk);
        // Reset values, both instances.
        check("rst.m_hcount", 32'(m_h), 32'd0);
        check("rst.m_hsync",  32'(m_hs), 32'd1);
        check("rst.m_vsync",  32'(m_vs), 32'd1);
        check("rst.m_vis",    32'(m_vi), 32'd1);
        check("rst.m_fetch",  32'(m_fe), 32'd1);
        check("rst.s_hsync",  32'(s_hs), 32'd0);
        check("rst.s_vsync",  32'(s_vs), 32'd0);
        check("rst.s_fetch",  32'(s_fe), 32'd1);

        // Free-running, ce=1: boundary literals in position order.
        rst = 1'b0;
        ce  = 1'b1;
        goto(9);    check("s_hsync_h9",  32'(s_hs), 32'd0);
        goto(10);   check("s_hsync_h10", 32'(s_hs), 32'd1);
        goto(12);   check("s_hsync_h12", 32'(s_hs), 32'd1);
        goto(13);   check("s_hsync_h13", 32'(s_hs), 32'd0);
        goto(57);   check("m_fetch_l0_h57", 32'(m_fe), 32'd1);
        goto(58);   check("m_fetch_l0_h58", 32'(m_fe), 32'd0);
        goto(64);   check("m_hblank_h64", 32'(m_hb), 32'd1);
                    check("m_vis_h64",    32'(m_vi), 32'd0);
        goto(67);   check("m_hsync_h67", 32'(m_hs), 32'd1);
        goto(68);   check("m_hsync_h68", 32'(m_hs), 32'd0);
        goto(74);   check("m_fetch_l0_h74", 32'(m_fe), 32'd1);
        goto(75);   check("m_hsync_h75", 32'(m_hs), 32'd0);
        goto(76);   check("m_hsync_h76", 32'(m_hs), 32'd1);
        goto(127);  check("s_frame_end", 32'(s_fr), 32'd1);
                    check("s_hcount_15", 32'(s_h), 32'd15);
                    check("s_vcount_7",  32'(s_v), 32'd7);
        goto(3760); check("m_fetch_l47_h0",  32'(m_fe), 32'd1);
        goto(3834); check("m_fetch_l47_h74", 32'(m_fe), 32'd0);
        goto(3999); check("m_vsync_l49",     32'(m_vs), 32'd1);
        goto(4000); check("m_vsync_l50",     32'(m_vs), 32'd0);
        goto(4160); check("m_vsync_l52",     32'(m_vs), 32'd1);
        goto(4320); check("m_fetch_l54_h0",  32'(m_fe), 32'd0);
        goto(4394); check("m_fetch_l54_h74", 32'(m_fe), 32'd1);
        goto(4399); check("m_line_end",      32'(m_le), 32'd1);
                    check("m_frame_end",     32'(m_fr), 32'd1);
        // A second full frame under the per-cycle model.
        tick();
        goto(4399); check("m_frame_end_2", 32'(m_fr), 32'd1);

        // ce toggling 1,0: each value held two clocks, line_end only with ce.
        for (int i = 0; i < 400; i++) begin
            ce = (i % 2 == 0);
            tick();
        end

        // Mid-frame reset at line 30, pixel 70, held three clocks.
        ce = 1'b1;
        goto(30 * 80 + 70);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check("midrst.hcount", 32'(m_h),  32'd0);
            check("midrst.vcount", 32'(m_v),  32'd0);
            check("midrst.hsync",  32'(m_hs), 32'd1);
            check("midrst.vblank", 32'(m_vb), 32'd0);
            check("midrst.fetch",  32'(m_fe), 32'd1);
            check("midrst.line_end", 32'(m_le), 32'd0);
        end
        rst = 1'b0;
        tick();
        @(negedge clk);
        check("after_rst.hcount", 32'(m_h), 32'd1);
        goto(3999); check("after_rst.vsync_l49", 32'(m_vs), 32'd1);
        goto(4000); check("after_rst.vsync_l50", 32'(m_vs), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised horizontal and vertical VGA timing generator. It is the successor to the fixed 640x480 horizontal counter. It produces both counters, sync with configurable polarity, blanking, and a visible-area flag. It also produces a configurable early "fetch" window, so that pipelined pixel sources can prefetch PRE clocks before the visible area. It sits between the pixel clock domain root and the framebuffer/pixel pipeline.

Parameters:
CNT_W, 12, width of hcount/vcount; must hold H_TOTAL-1 and V_TOTAL-1, otherwise elaboration error
H_VIS, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, hsync width
H_BP, 48, horizontal back porch
V_VIS, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
H_SYNC_POL, 0, asserted level of hsync (0 = active low)
V_SYNC_POL, 0, asserted level of vsync
PRE, 6, fetch lead in clocks; 0 <= PRE <= H_FP+H_SYNC+H_BP, otherwise elaboration error

Ports:
clk  in  1  pixel-domain clock
rst  in  1  synchronous reset, active high
ce  in  1  pixel enable; counters advance only when high
hcount  out  CNT_W  current horizontal position, 0..H_TOTAL-1
vcount  out  CNT_W  current line, 0..V_TOTAL-1
hsync  out  1  horizontal sync, polarity per H_SYNC_POL
vsync  out  1  vertical sync, polarity per V_SYNC_POL
hblank  out  1  high when hcount >= H_VIS
vblank  out  1  high when vcount >= V_VIS
vis  out  1  ~hblank & ~vblank
fetch  out  1  visible window advanced by PRE clocks
line_end  out  1  ce & (hcount == H_TOTAL-1)
frame_end  out  1  line_end & (vcount == V_TOTAL-1)

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Derived totals: H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP; V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP.
- Reset values (rst dominates ce):
  - hcount=0, vcount=0
  - hsync=~H_SYNC_POL, vsync=~V_SYNC_POL
  - hblank=0, vblank=0, vis=1
  - fetch=1 if PRE < H_VIS (else 0)
  - line_end=0, frame_end=0
- Counting, on each clk with ce=1:
  - hcount increments; at H_TOTAL-1 it wraps to 0.
  - vcount increments on hcount wrap; at V_TOTAL-1, together with hcount wrap, it wraps to 0.
- ce=0: all registers hold; line_end and frame_end are 0.
- hsync, vsync, hblank, vblank and fetch are registers, computed from next-state counter values. They are therefore always consistent with the hcount/vcount presented in the same cycle, and glitch-free.
- hsync asserted for hcount in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1].
- vsync asserted for vcount in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1], over whole lines, changing at hcount=0.
- fetch asserted when either:
  - vcount < V_VIS and hcount <= H_VIS-PRE-1, or
  - hcount >= H_TOTAL-PRE and ((vcount+1) mod V_TOTAL) < V_VIS.
- fetch lead across frames: the lead into line 0 occurs on line V_TOTAL-1. No lead occurs on line V_VIS-1.
- PRE=0: fetch is identical to vis.
- line_end and frame_end are combinational, single-cycle, and qualified by ce.
- Reset mid-frame: counters and all outputs return to their reset values on the next clk edge. Counting resumes from 0,0 on the first ce after rst deasserts.
- All comparisons use unsigned CNT_W arithmetic; no counter ever exceeds its TOTAL-1.

Test Plan:
- Defaults, ce=1 constant, 2 frames:
  - line period is 800 clks; hsync low exactly for hcount 656..751; hblank rises at hcount 640.
  - frame_end pulses every 420000 clks; vsync low for lines 490..491.
- Fetch window, defaults:
  - line 0: fetch high for hcount 0..633 and 794..799.
  - line 479: fetch high for hcount 0..633 only.
  - line 524: fetch high for hcount 794..799 only.
  - lines 480..523: fetch never high.
- ce pattern 1,0 repeating: each count value is held 2 clks; line period is 1600 clks; line_end is high only in the ce=1 cycle at hcount 799.
- rst asserted at hcount=700, vcount=300 for 3 clks: outputs show reset values from the first edge; after release, hcount=1 one ce-clk later; vsync first asserts at line 490 of the new frame.
- Small config for fast sim (H_VIS=8, H_FP=2, H_SYNC=3, H_BP=3, V_VIS=4, V_FP=1, V_SYNC=1, V_BP=2, both POL=1, PRE=0):
  - hsync high for hcount 10..12; frame is 16x8=128 clks.
  - fetch equals vis every cycle.
- Parameter check: CNT_W=9 with the default H parameters fails elaboration.
